// File: rtl/memory_bank.sv
// memory_bank: single-clock word memory, one write port and one registered
// read port, per-byte write enables and a hardware zero-fill sweep.
//
// Ports:
//   clk, reset       rising-edge clock, async active-high reset
//   clear            start (or restart) a zero-fill sweep of the array
//   wr_en/addr/data  write request; wr_be[k] enables wr_data[8k+7:8k]
//   rd_en/rd_addr    read request; result one cycle later on rd_data
//   rd_data          registered read data, held while rd_valid=0
//   rd_valid         one-cycle strobe per accepted read
//   busy             sweep in progress, requests are rejected
//   drop             one-cycle pulse after a rejected request

// One byte lane of storage: a write port and an asynchronous read port.
// The registered read stage lives in the top level so all lanes share it.
module memory_bank_lane #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [7:0]            wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [7:0]            rdata
);
    logic [7:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

module memory_bank #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    drop
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t                      state, state_nxt;
    logic [ADDR_WIDTH-1:0]       ptr, ptr_nxt;
    logic                        accept, wr_ok, rd_ok;
    logic [ADDR_WIDTH-1:0]       lane_waddr;
    logic [BE_WIDTH-1:0]         lane_we;
    logic [BE_WIDTH-1:0][7:0]    lane_wdata;
    logic [BE_WIDTH-1:0][7:0]    rd_word;

    assign busy   = (state == S_CLEAR);
    // clear wins over any same-cycle request
    assign accept = ~busy & ~clear;
    assign wr_ok  = accept & wr_en;
    assign rd_ok  = accept & rd_en;

    // ---------------- sweep FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            S_CLEAR: begin
                ptr_nxt = ptr + 1'b1;
                if (clear)          ptr_nxt   = '0;
                else if (ptr == '1) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (clear) begin
                    state_nxt = S_CLEAR;
                    ptr_nxt   = '0;
                end
            end
            default: state_nxt = S_CLEAR;
        endcase
    end

    // ---------------- storage lanes ----------------
    // While sweeping, the write port is stolen by the clear engine.
    assign lane_waddr = busy ? ptr : wr_addr;
    assign lane_wdata = busy ? '0 : wr_data;

    always_comb begin
        lane_we = '0;
        for (int k = 0; k < BE_WIDTH; k++)
            lane_we[k] = busy | (wr_ok & wr_be[k]);
    end

    for (genvar g = 0; g < BE_WIDTH; g++) begin : g_lane
        memory_bank_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
            .clk   (clk),
            .we    (lane_we[g]),
            .waddr (lane_waddr),
            .wdata (lane_wdata[g]),
            .raddr (rd_addr),
            .rdata (rd_word[g])
        );
    end

    // ---------------- read stage / drop ----------------
    // Read samples the array before this edge's write lands: read-first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            drop     <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) rd_data <= rd_word;
            drop     <= (rd_en | wr_en) & ~accept;
        end
    end
endmodule

// File: tb/tb_memory_bank.sv
module tb_memory_bank;
    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset, clear, wr_en, rd_en;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data, rd_data;
    logic [3:0]    wr_be;
    logic          rd_valid, busy, drop;

    int checks = 0;
    int errors = 0;

    memory_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Ticks until busy falls (bounded); returns number of ticks taken.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic idle_inputs;
        clear = 0; wr_en = 0; rd_en = 0;
        wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = '0;
    endtask

    task automatic test_reset;
        int n;
        reset = 1'b1;
        idle_inputs();
        tick(); tick();
        checks++;
        if (busy !== 1'b1 || rd_valid !== 1'b0 || rd_data !== '0 || drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_state busy=%b rd_valid=%b rd_data=%h drop=%b want 1 0 0 0",
                     busy, rd_valid, rd_data, drop);
        end
        reset = 1'b0;
        wait_idle(n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL reset_sweep_len got %0d cycles want 16", n);
        end
        rd_en = 1;
        for (int a = 0; a < 16; a++) begin
            rd_addr = AW'(a);
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
                errors++;
                $display("FAIL init_read addr=%0d rd_valid=%b rd_data=%h want 1 00000000",
                         a, rd_valid, rd_data);
            end
        end
        rd_en = 0;
        tick();
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL init_read_end rd_valid=%b want 0", rd_valid);
        end
    endtask

    task automatic test_write_read;
        wr_en = 1; wr_addr = 3; wr_data = 32'hDEADBEEF; wr_be = 4'b1111;
        tick();
        wr_en = 0; rd_en = 1; rd_addr = 3;
        tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'hDEADBEEF || drop !== 1'b0) begin
            errors++;
            $display("FAIL write_read rd_valid=%b rd_data=%h drop=%b want 1 deadbeef 0",
                     rd_valid, rd_data, drop);
        end
        rd_en = 0;
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_hold rd_valid=%b rd_data=%h want 0 deadbeef", rd_valid, rd_data);
        end
    endtask

    task automatic test_byte_enable;
        wr_en = 1; wr_addr = 3; wr_data = 32'h11223344; wr_be = 4'b0101;
        tick();
        wr_en = 0; rd_en = 1; rd_addr = 3;
        tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL byte_enable rd_valid=%b rd_data=%h want 1 de22be44", rd_valid, rd_data);
        end
        rd_en = 0; wr_en = 1; wr_data = 32'hFFFFFFFF; wr_be = 4'b0000;
        tick();
        checks++;
        if (drop !== 1'b0) begin
            errors++;
            $display("FAIL be_zero_drop drop=%b want 0", drop);
        end
        wr_en = 0; rd_en = 1; rd_addr = 3;
        tick();
        checks++;
        if (rd_data !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL be_zero_noop rd_data=%h want de22be44", rd_data);
        end
        rd_en = 0;
        tick();
    endtask

    task automatic test_read_first;
        wr_en = 1; wr_addr = 5; wr_data = 32'hAAAA5555; wr_be = 4'b1111;
        rd_en = 1; rd_addr = 5;
        tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
            errors++;
            $display("FAIL read_first rd_valid=%b rd_data=%h want 1 00000000", rd_valid, rd_data);
        end
        wr_en = 0;
        tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'hAAAA5555) begin
            errors++;
            $display("FAIL read_after_write rd_valid=%b rd_data=%h want 1 aaaa5555",
                     rd_valid, rd_data);
        end
        // different addresses in the same cycle
        wr_en = 1; wr_addr = 9; wr_data = 32'h0BADCAFE; rd_addr = 3;
        tick();
        checks++;
        if (rd_data !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL diff_addr_read rd_data=%h want de22be44", rd_data);
        end
        wr_en = 0; rd_addr = 9;
        tick();
        checks++;
        if (rd_data !== 32'h0BADCAFE) begin
            errors++;
            $display("FAIL diff_addr_write rd_data=%h want 0badcafe", rd_data);
        end
        rd_en = 0;
        tick();
    endtask

    task automatic test_clear;
        int n;
        clear = 1; wr_en = 1; wr_addr = 7; wr_data = 32'h12345678; wr_be = 4'b1111;
        tick();
        checks++;
        if (drop !== 1'b1 || busy !== 1'b1 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_start drop=%b busy=%b rd_valid=%b want 1 1 0", drop, busy, rd_valid);
        end
        clear = 0; wr_en = 0;
        tick();
        checks++;
        if (drop !== 1'b0) begin
            errors++;
            $display("FAIL clear_drop_once drop=%b want 0", drop);
        end
        wr_en = 1;
        tick();
        checks++;
        if (drop !== 1'b1 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_write drop=%b rd_valid=%b want 1 0", drop, rd_valid);
        end
        rd_en = 1; rd_addr = 7;
        tick();
        checks++;
        if (drop !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 32'h0BADCAFE) begin
            errors++;
            $display("FAIL busy_rdwr drop=%b rd_valid=%b rd_data=%h want 1 0 0badcafe",
                     drop, rd_valid, rd_data);
        end
        rd_en = 0; wr_en = 0;
        tick();
        checks++;
        if (drop !== 1'b0) begin
            errors++;
            $display("FAIL busy_drop_end drop=%b want 0", drop);
        end
        wait_idle(n);
        checks++;
        if (n + 4 !== 16) begin
            errors++;
            $display("FAIL clear_sweep_len got %0d cycles want 16", n + 4);
        end
        rd_en = 1;
        rd_addr = 3; tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
            errors++;
            $display("FAIL clear_addr3 rd_valid=%b rd_data=%h want 1 0", rd_valid, rd_data);
        end
        rd_addr = 5; tick();
        checks++;
        if (rd_data !== 32'h0) begin
            errors++;
            $display("FAIL clear_addr5 rd_data=%h want 0", rd_data);
        end
        rd_addr = 7; tick();
        checks++;
        if (rd_data !== 32'h0) begin
            errors++;
            $display("FAIL clear_addr7 rd_data=%h want 0", rd_data);
        end
        rd_en = 0;
        tick();
    endtask

    task automatic test_reset_mid_sweep;
        int n;
        wr_en = 1; wr_addr = 2; wr_data = 32'hCAFEF00D; wr_be = 4'b1111;
        tick();
        wr_en = 0; rd_en = 1; rd_addr = 2;
        tick();
        rd_en = 0;
        checks++;
        if (rd_data !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL pre_reset_read rd_data=%h want cafef00d", rd_data);
        end
        clear = 1;
        tick();
        clear = 0;
        repeat (7) tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (rd_data !== 32'h0 || rd_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL async_reset rd_data=%h rd_valid=%b busy=%b want 0 0 1",
                     rd_data, rd_valid, busy);
        end
        tick(); tick();
        reset = 1'b0;
        wait_idle(n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL resweep_len got %0d cycles want 16", n);
        end
        rd_en = 1;
        for (int a = 0; a < 16; a++) begin
            rd_addr = AW'(a);
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
                errors++;
                $display("FAIL resweep_read addr=%0d rd_valid=%b rd_data=%h want 1 00000000",
                         a, rd_valid, rd_data);
            end
        end
        rd_en = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_read_first();
        test_clear();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
